// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb_pkg
// Purpose  : Shared types and defaults for the register-file write-port
//            arbiter and its long-latency-unit result FIFO.
// Contents : XLEN_DEFAULT / REG_AW_DEFAULT  - default data / address widths
//            wb_arb_state_e                 - arbiter FSM state
//            llu_entry_t                    - buffered LLU result {data, rd}
// Revision : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

    localparam int XLEN_DEFAULT   = 32;
    localparam int REG_AW_DEFAULT = 5;

    // NORMAL: pipeline has priority. FORCE: LLU head has priority and the
    // pipeline is stalled if it also wants the port.
    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } wb_arb_state_e;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0]   data;
        logic [REG_AW_DEFAULT-1:0] rd;
    } llu_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_llu_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_llu_fifo
// Purpose  : Small synchronous FIFO holding LLU results until they win the
//            register-file write port.
// Ports    : clk, rst_n     - clock / asynchronous active-low reset
//            push/push_data - write request and entry (ignored when full)
//            pop            - remove head (ignored when empty)
//            full, empty    - occupancy flags
//            last           - exactly one entry held
//            head           - oldest entry (valid when !empty)
// Revision : 1.0 - initial release
// ============================================================================
module wb_llu_fifo
    import wb_arb_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type ENTRY_T = llu_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  ENTRY_T push_data,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output logic   last,
    output ENTRY_T head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ENTRY_T           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign last    = (count == CNT_ONE);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: clearing count is enough to discard contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Owns the single register-file write port. Arbitrates between
//            the in-order pipeline writeback and buffered long-latency-unit
//            (LLU) results, tracks LLU destinations pending in a scoreboard,
//            and stalls the pipeline when LLU results would starve.
// Ports    : i_clk, i_reset              - clock / async active-low reset
//            i_wb_*                      - pipeline writeback request
//            i_llu_*, o_llu_ready        - LLU result handshake
//            i_issue_*, o_issue_ready    - LLU issue (blocked on WAW)
//            i_rs*_addr, o_rs*_busy      - decode hazard lookup
//            o_pipe_stall                - freeze pipeline, WB must hold
//            o_rf_wren/addr/data         - register-file write port
//            o_fwd_rd_addr               - address written now (0 if none)
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int XLEN         = XLEN_DEFAULT,
    parameter int REG_AW       = REG_AW_DEFAULT,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [XLEN-1:0]   i_wb_data,
    input  logic [REG_AW-1:0] i_wb_rd_addr,
    input  logic              i_wb_rd_wren,
    input  logic              i_llu_valid,
    input  logic [XLEN-1:0]   i_llu_data,
    input  logic [REG_AW-1:0] i_llu_rd,
    output logic              o_llu_ready,
    input  logic              i_issue_valid,
    input  logic [REG_AW-1:0] i_issue_rd,
    output logic              o_issue_ready,
    input  logic [REG_AW-1:0] i_rs1_addr,
    input  logic [REG_AW-1:0] i_rs2_addr,
    output logic              o_rs1_busy,
    output logic              o_rs2_busy,
    output logic              o_pipe_stall,
    output logic              o_rf_wren,
    output logic [REG_AW-1:0] o_rf_addr,
    output logic [XLEN-1:0]   o_rf_data,
    output logic [REG_AW-1:0] o_fwd_rd_addr
);

    typedef struct packed {
        logic [XLEN-1:0]   data;
        logic [REG_AW-1:0] rd;
    } entry_t;

    localparam int NREG  = 1 << REG_AW;
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_LIMIT);
    localparam logic [AGE_W-1:0] AGE_TRIP = AGE_W'(STARVE_LIMIT - 1);

    wb_arb_state_e    state;
    wb_arb_state_e    state_nxt;
    logic [AGE_W-1:0] age;
    logic [NREG-1:0]  pending;

    entry_t push_entry;
    entry_t head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   fifo_last;

    logic   pipe_req;
    logic   llu_req;
    logic   grant_pipe;
    logic   grant_llu;
    logic   push_store;
    logic   issue_set;

    // ------------------------------------------------------------------
    // Requests and grant
    // ------------------------------------------------------------------
    assign pipe_req = i_wb_rd_wren && (i_wb_rd_addr != '0);
    assign llu_req  = !fifo_empty;

    // Grants are masked by reset so the write port is quiet while reset is
    // held, independent of what the pipeline is presenting.
    always_comb begin
        grant_pipe = 1'b0;
        grant_llu  = 1'b0;
        if (i_reset) begin
            if (state == FORCE) begin
                grant_llu  = llu_req;
                grant_pipe = pipe_req && !llu_req;
            end else begin
                grant_pipe = pipe_req;
                grant_llu  = llu_req && !pipe_req;
            end
        end
    end

    assign o_pipe_stall = (state == FORCE) && pipe_req && llu_req;

    // ------------------------------------------------------------------
    // LLU result FIFO. rd==0 results are acknowledged but never stored.
    // ------------------------------------------------------------------
    assign o_llu_ready = !fifo_full;
    assign push_store  = i_llu_valid && !fifo_full && (i_llu_rd != '0);
    assign push_entry  = '{data: i_llu_data, rd: i_llu_rd};

    wb_llu_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .ENTRY_T (entry_t)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_reset),
        .push      (push_store),
        .push_data (push_entry),
        .pop       (grant_llu),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .last      (fifo_last),
        .head      (head)
    );

    // ------------------------------------------------------------------
    // Register-file write port (combinational, zero added latency)
    // ------------------------------------------------------------------
    always_comb begin
        o_rf_wren = grant_pipe || grant_llu;
        o_rf_addr = '0;
        o_rf_data = '0;
        if (grant_llu) begin
            o_rf_addr = head.rd;
            o_rf_data = head.data;
        end else if (grant_pipe) begin
            o_rf_addr = i_wb_rd_addr;
            o_rf_data = i_wb_data;
        end
    end

    assign o_fwd_rd_addr = o_rf_wren ? o_rf_addr : '0;

    // ------------------------------------------------------------------
    // Arbitration FSM and head age
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            NORMAL: begin
                if (llu_req && !grant_llu && (fifo_full || age >= AGE_TRIP))
                    state_nxt = FORCE;
            end
            FORCE: begin
                // Leave only when this pop empties the FIFO.
                if (grant_llu && fifo_last && !push_store)
                    state_nxt = NORMAL;
            end
            default: state_nxt = NORMAL;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= NORMAL;
            age   <= '0;
        end else begin
            state <= state_nxt;
            if (grant_llu || !llu_req)
                age <= '0;
            else if (age != AGE_MAX)
                age <= age + AGE_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard of LLU destinations in flight
    // ------------------------------------------------------------------
    assign o_issue_ready = (i_issue_rd == '0) || !pending[i_issue_rd];
    assign issue_set     = i_issue_valid && o_issue_ready && (i_issue_rd != '0);

    // Busy follows the registered bit only, so a clear happening this cycle
    // still reports busy (conservative for decode).
    assign o_rs1_busy = pending[i_rs1_addr] && (i_rs1_addr != '0);
    assign o_rs2_busy = pending[i_rs2_addr] && (i_rs2_addr != '0);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pending <= '0;
        end else begin
            if (grant_llu) pending[head.rd]    <= 1'b0;
            if (issue_set) pending[i_issue_rd] <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Purpose  : Self-checking bench for wb_port_arbiter: table vectors, directed
//            multi-cycle sequences and randomized traffic against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_wb_port_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic [31:0] i_wb_data;
    logic [4:0]  i_wb_rd_addr;
    logic        i_wb_rd_wren;
    logic        i_llu_valid;
    logic [31:0] i_llu_data;
    logic [4:0]  i_llu_rd;
    logic        o_llu_ready;
    logic        i_issue_valid;
    logic [4:0]  i_issue_rd;
    logic        o_issue_ready;
    logic [4:0]  i_rs1_addr;
    logic [4:0]  i_rs2_addr;
    logic        o_rs1_busy;
    logic        o_rs2_busy;
    logic        o_pipe_stall;
    logic        o_rf_wren;
    logic [4:0]  o_rf_addr;
    logic [31:0] o_rf_data;
    logic [4:0]  o_fwd_rd_addr;

    always #5 i_clk = ~i_clk;

    wb_port_arbiter #(
        .XLEN(32), .REG_AW(5), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_wb_data(i_wb_data), .i_wb_rd_addr(i_wb_rd_addr), .i_wb_rd_wren(i_wb_rd_wren),
        .i_llu_valid(i_llu_valid), .i_llu_data(i_llu_data), .i_llu_rd(i_llu_rd),
        .o_llu_ready(o_llu_ready),
        .i_issue_valid(i_issue_valid), .i_issue_rd(i_issue_rd), .o_issue_ready(o_issue_ready),
        .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
        .o_rs1_busy(o_rs1_busy), .o_rs2_busy(o_rs2_busy),
        .o_pipe_stall(o_pipe_stall),
        .o_rf_wren(o_rf_wren), .o_rf_addr(o_rf_addr), .o_rf_data(o_rf_data),
        .o_fwd_rd_addr(o_fwd_rd_addr)
    );

    typedef struct {
        logic        wb_wren;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        llu_valid;
        logic [4:0]  llu_rd;
        logic [31:0] llu_data;
        logic        issue_valid;
        logic [4:0]  issue_rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } stim_t;

    typedef struct {
        stim_t       in;
        logic        e_wren;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_stall;
        logic        e_iready;
        logic        e_b1;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
    } ent_t;

    // Reference model: results waiting in arrival order, registers in flight,
    // whether the LLU currently has priority, and how long the head has waited.
    ent_t q[$];
    bit   pend[32];
    bit   forcing;
    int   head_wait;

    stim_t s;
    vec_t  tbl[7];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    n_proto = 0;

    logic        sn_wren, sn_stall, sn_lready, sn_iready, sn_b1;
    logic [4:0]  sn_addr;
    logic [31:0] sn_data;

    function automatic stim_t idle();
        stim_t t;
        t = '{default: '0};
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        foreach (pend[i]) pend[i] = 1'b0;
        forcing   = 1'b0;
        head_wait = 0;
    endtask

    task automatic drive();
        i_wb_rd_wren  = s.wb_wren;
        i_wb_rd_addr  = s.wb_rd;
        i_wb_data     = s.wb_data;
        i_llu_valid   = s.llu_valid;
        i_llu_rd      = s.llu_rd;
        i_llu_data    = s.llu_data;
        i_issue_valid = s.issue_valid;
        i_issue_rd    = s.issue_rd;
        i_rs1_addr    = s.rs1;
        i_rs2_addr    = s.rs2;
    endtask

    // One clock: drive at negedge, check against the model, advance at posedge.
    task automatic step();
        bit          preq, has, gl, gp, st, lready, iready, pushed;
        int          sz;
        logic [4:0]  ea;
        logic [31:0] ed;
        ent_t        e;
        @(negedge i_clk);
        drive();
        #1;
        sz     = q.size();
        has    = (sz > 0);
        preq   = s.wb_wren && (s.wb_rd != 0);
        gl     = has && (forcing || !preq);
        gp     = preq && !gl;
        st     = forcing && preq && has;
        lready = (sz < DEPTH);
        iready = (s.issue_rd == 0) || !pend[s.issue_rd];
        ea = 5'd0;
        ed = 32'd0;
        if (gl) begin
            ea = q[0].rd;
            ed = q[0].data;
        end else if (gp) begin
            ea = s.wb_rd;
            ed = s.wb_data;
        end
        chk("rf_wren", o_rf_wren, gl || gp);
        chk("rf_addr", o_rf_addr, ea);
        chk("rf_data", o_rf_data, ed);
        chk("fwd_rd_addr", o_fwd_rd_addr, ea);
        chk("pipe_stall", o_pipe_stall, st);
        chk("llu_ready", o_llu_ready, lready);
        chk("issue_ready", o_issue_ready, iready);
        chk("rs1_busy", o_rs1_busy, pend[s.rs1] && s.rs1 != 0);
        chk("rs2_busy", o_rs2_busy, pend[s.rs2] && s.rs2 != 0);
        sn_wren = o_rf_wren; sn_addr = o_rf_addr; sn_data = o_rf_data;
        sn_stall = o_pipe_stall; sn_lready = o_llu_ready;
        sn_iready = o_issue_ready; sn_b1 = o_rs1_busy;
        @(posedge i_clk);
        pushed = s.llu_valid && lready && (s.llu_rd != 0);
        if (gl) begin
            e = q.pop_front();
            if (!pend[e.rd]) n_proto++;
            pend[e.rd] = 1'b0;
        end
        if (s.issue_valid && iready && s.issue_rd != 0) pend[s.issue_rd] = 1'b1;
        if (pushed) q.push_back('{data: s.llu_data, rd: s.llu_rd});
        if (!forcing) begin
            if (has && !gl && (sz == DEPTH || head_wait >= LIMIT - 1)) forcing = 1'b1;
        end else if (gl && sz == 1 && !pushed) begin
            forcing = 1'b0;
        end
        if (gl || !has) head_wait = 0;
        else if (head_wait < LIMIT) head_wait++;
    endtask

    initial begin
        // ---------------- table vectors: basic writes and scoreboard -------
        for (int i = 0; i < 7; i++) begin
            tbl[i].in = idle();
            tbl[i].in.rs1 = 5'd7;
            tbl[i].in.issue_rd = 5'd7;
        end
        tbl[0].in.issue_rd = 5'd0;
        tbl[0].in.wb_wren = 1'b1; tbl[0].in.wb_rd = 5'd5; tbl[0].in.wb_data = 32'hA5;
        tbl[1].in.issue_rd = 5'd0;
        tbl[1].in.wb_wren = 1'b1; tbl[1].in.wb_rd = 5'd0; tbl[1].in.wb_data = 32'hA5;
        tbl[2].in.issue_valid = 1'b1;
        tbl[3].in.issue_valid = 1'b1;
        tbl[4].in.llu_valid = 1'b1; tbl[4].in.llu_rd = 5'd7; tbl[4].in.llu_data = 32'h1234;
        //                 wren  addr   data          stall iready b1
        tbl[0].e_wren = 1; tbl[0].e_addr = 5; tbl[0].e_data = 32'hA5;   tbl[0].e_stall = 0; tbl[0].e_iready = 1; tbl[0].e_b1 = 0;
        tbl[1].e_wren = 0; tbl[1].e_addr = 0; tbl[1].e_data = 32'h0;    tbl[1].e_stall = 0; tbl[1].e_iready = 1; tbl[1].e_b1 = 0;
        tbl[2].e_wren = 0; tbl[2].e_addr = 0; tbl[2].e_data = 32'h0;    tbl[2].e_stall = 0; tbl[2].e_iready = 1; tbl[2].e_b1 = 0;
        tbl[3].e_wren = 0; tbl[3].e_addr = 0; tbl[3].e_data = 32'h0;    tbl[3].e_stall = 0; tbl[3].e_iready = 0; tbl[3].e_b1 = 1;
        tbl[4].e_wren = 0; tbl[4].e_addr = 0; tbl[4].e_data = 32'h0;    tbl[4].e_stall = 0; tbl[4].e_iready = 0; tbl[4].e_b1 = 1;
        tbl[5].e_wren = 1; tbl[5].e_addr = 7; tbl[5].e_data = 32'h1234; tbl[5].e_stall = 0; tbl[5].e_iready = 0; tbl[5].e_b1 = 1;
        tbl[6].e_wren = 0; tbl[6].e_addr = 0; tbl[6].e_data = 32'h0;    tbl[6].e_stall = 0; tbl[6].e_iready = 1; tbl[6].e_b1 = 0;

        // ---------------- reset state (WB request present but masked) -----
        s = idle();
        s.wb_wren = 1'b1; s.wb_rd = 5'd5; s.wb_data = 32'hA5;
        drive();
        model_reset();
        sn_stall = 1'b0;
        #12;
        chk("rst_rf_wren", o_rf_wren, 0);
        chk("rst_rf_addr", o_rf_addr, 0);
        chk("rst_rf_data", o_rf_data, 0);
        chk("rst_stall", o_pipe_stall, 0);
        chk("rst_llu_ready", o_llu_ready, 1);
        chk("rst_issue_ready", o_issue_ready, 1);
        @(negedge i_clk);
        i_reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            s = tbl[i].in;
            step();
            chk($sformatf("vec%0d_wren", i), sn_wren, tbl[i].e_wren);
            chk($sformatf("vec%0d_addr", i), sn_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d_data", i), sn_data, tbl[i].e_data);
            chk($sformatf("vec%0d_stall", i), sn_stall, tbl[i].e_stall);
            chk($sformatf("vec%0d_iready", i), sn_iready, tbl[i].e_iready);
            chk($sformatf("vec%0d_rs1_busy", i), sn_b1, tbl[i].e_b1);
        end

        // ---------------- starvation: single result under WB pressure -----
        s = idle();
        s.wb_wren = 1'b1; s.wb_rd = 5'd1; s.wb_data = 32'h100;
        s.llu_valid = 1'b1; s.llu_rd = 5'd9; s.llu_data = 32'hBEEF;
        s.issue_valid = 1'b1; s.issue_rd = 5'd9;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) begin
                s.llu_valid = 1'b0;
                s.issue_valid = 1'b0;
                if (!sn_stall) begin
                    s.wb_rd = 5'(k + 1);
                    s.wb_data = 32'h100 + 32'(k);
                end
            end
            step();
            if (k < 5) begin
                chk("starve_pipe_addr", sn_addr, 32'(k + 1));
                chk("starve_no_stall", sn_stall, 0);
            end else if (k == 5) begin
                chk("starve_llu_addr", sn_addr, 9);
                chk("starve_llu_data", sn_data, 32'hBEEF);
                chk("starve_stall", sn_stall, 1);
            end else begin
                chk("starve_held_addr", sn_addr, 6);
                chk("starve_held_data", sn_data, 32'h105);
                chk("starve_held_stall", sn_stall, 0);
            end
        end

        // ---------------- full FIFO drains over two forced cycles ---------
        s = idle();
        s.issue_valid = 1'b1; s.issue_rd = 5'd10; step();
        s.issue_rd = 5'd11; step();
        s.issue_valid = 1'b0;
        s.wb_wren = 1'b1; s.wb_rd = 5'd3; s.wb_data = 32'h300;
        for (int k = 0; k < 6; k++) begin
            s.llu_valid = (k < 2);
            s.llu_rd = 5'(10 + k);
            s.llu_data = 32'hD0 + 32'(k);
            if (k > 0 && !sn_stall) s.wb_data = 32'h300 + 32'(k);
            step();
            case (k)
                2: chk("full_llu_ready", sn_lready, 0);
                3: begin
                    chk("drain0_addr", sn_addr, 10);
                    chk("drain0_data", sn_data, 32'hD0);
                    chk("drain0_stall", sn_stall, 1);
                end
                4: begin
                    chk("drain1_addr", sn_addr, 11);
                    chk("drain1_data", sn_data, 32'hD1);
                    chk("drain1_stall", sn_stall, 1);
                end
                5: begin
                    chk("drain_done_addr", sn_addr, 3);
                    chk("drain_done_data", sn_data, 32'h303);
                    chk("drain_done_stall", sn_stall, 0);
                end
                default: chk("pre_full_llu_ready", sn_lready, 1);
            endcase
        end

        // ---------------- simultaneous push and pop keeps order -----------
        s = idle();
        s.issue_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s.issue_rd = 5'(12 + k);
            step();
        end
        s.issue_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            s.llu_valid = (k < 3);
            s.llu_rd = 5'(12 + k);
            s.llu_data = 32'hE0 + 32'(k);
            step();
            if (k == 0 || k == 4) begin
                chk("pushpop_idle_wren", sn_wren, 0);
            end else begin
                chk("pushpop_addr", sn_addr, 32'(11 + k));
                chk("pushpop_data", sn_data, 32'hE0 + 32'(k - 1));
            end
        end

        // ---------------- async reset with full FIFO and pending bits -----
        s = idle();
        s.issue_valid = 1'b1; s.issue_rd = 5'd20; step();
        s.issue_rd = 5'd21; step();
        s.issue_valid = 1'b0;
        s.wb_wren = 1'b1; s.wb_rd = 5'd4; s.wb_data = 32'h400;
        s.llu_valid = 1'b1; s.llu_rd = 5'd20; s.llu_data = 32'hF0; step();
        s.llu_rd = 5'd21; s.llu_data = 32'hF1; step();
        s.llu_valid = 1'b0; s.issue_rd = 5'd20; s.rs1 = 5'd20; s.rs2 = 5'd21;
        @(negedge i_clk);
        drive();
        #2;
        i_reset = 1'b0;
        #1;
        chk("arst_rf_wren", o_rf_wren, 0);
        chk("arst_rf_addr", o_rf_addr, 0);
        chk("arst_rf_data", o_rf_data, 0);
        chk("arst_fwd", o_fwd_rd_addr, 0);
        chk("arst_stall", o_pipe_stall, 0);
        chk("arst_llu_ready", o_llu_ready, 1);
        chk("arst_issue_ready", o_issue_ready, 1);
        chk("arst_rs1_busy", o_rs1_busy, 0);
        chk("arst_rs2_busy", o_rs2_busy, 0);
        model_reset();
        sn_stall = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b1;
        s.wb_wren = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("no_replay_wren", sn_wren, 0);
        end

        // ---------------- randomized traffic against the model ------------
        for (int c = 0; c < 600; c++) begin
            if (!sn_stall) begin
                s.wb_wren = ($urandom_range(0, 3) != 0);
                s.wb_rd   = 5'($urandom_range(0, 7));
                s.wb_data = $urandom;
            end
            s.llu_valid   = ($urandom_range(0, 2) == 0);
            s.llu_rd      = 5'($urandom_range(0, 7));
            s.llu_data    = $urandom;
            s.issue_valid = ($urandom_range(0, 2) == 0);
            s.issue_rd    = 5'($urandom_range(0, 7));
            s.rs1         = 5'($urandom_range(0, 7));
            s.rs2         = 5'($urandom_range(0, 7));
            step();
        end

        $display("note: %0d LLU results written for a non-pending rd (protocol error)", n_proto);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
